// File: rtl/fib_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fib_pkg
// Description : Shared constants for the Fibonacci pattern generator.
// Revision    : 1.0 - initial release
// ============================================================================
package fib_pkg;

   localparam int FIB_WIDTH_DEFAULT = 4;
   localparam int FIB_SEED0         = 0;
   localparam int FIB_SEED1         = 1;

endpackage : fib_pkg
`default_nettype wire

// File: rtl/fib_step.sv
`default_nettype none
// ============================================================================
// Module      : fib_step
// Description : Combinational next-term logic: adder plus restart mux.
// Revision    : 1.0 - initial release
// ============================================================================
module fib_step
   import fib_pkg::*;
#(
   parameter int WIDTH = FIB_WIDTH_DEFAULT
) (
   input  logic [WIDTH-1:0] i_cur,
   input  logic [WIDTH:0]   i_nxt,
   output logic [WIDTH-1:0] o_cur_n,
   output logic [WIDTH:0]   o_nxt_n,
   output logic             o_wrap
);

   localparam logic [WIDTH-1:0] C_SEED0 = WIDTH'(FIB_SEED0);
   localparam logic [WIDTH:0]   C_SEED1 = (WIDTH+1)'(FIB_SEED1);

   logic [WIDTH:0] w_sum;

   // cur <= nxt < 2**WIDTH, so the WIDTH+1-bit sum can never truncate
   assign w_sum  = {1'b0, i_cur} + i_nxt;
   assign o_wrap = i_nxt[WIDTH];

   always_comb begin
      o_cur_n = i_nxt[WIDTH-1:0];
      o_nxt_n = w_sum;
      if (o_wrap) begin
         o_cur_n = C_SEED0;
         o_nxt_n = C_SEED1;
      end
   end

endmodule : fib_step
`default_nettype wire

// File: rtl/fibonacci.sv
`default_nettype none
// ============================================================================
// Module      : fibonacci
// Description : Free-running Fibonacci term generator, one term per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module fibonacci
   import fib_pkg::*;
#(
   parameter int WIDTH = FIB_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   output logic [WIDTH-1:0] fib_out
);

   localparam logic [WIDTH-1:0] C_SEED0 = WIDTH'(FIB_SEED0);
   localparam logic [WIDTH:0]   C_SEED1 = (WIDTH+1)'(FIB_SEED1);

   logic [WIDTH-1:0] r_cur;
   logic [WIDTH:0]   r_nxt;
   logic [WIDTH-1:0] w_cur_n;
   logic [WIDTH:0]   w_nxt_n;
   logic             w_wrap;

   fib_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .i_cur   (r_cur),
      .i_nxt   (r_nxt),
      .o_cur_n (w_cur_n),
      .o_nxt_n (w_nxt_n),
      .o_wrap  (w_wrap)
   );

   // rst is active-low
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_cur <= C_SEED0;
         r_nxt <= C_SEED1;
      end else begin
         r_cur <= w_cur_n;
         r_nxt <= w_nxt_n;
      end
   end

   // On a wrap step the low bits of nxt are a truncated sum, so the ordering does not hold
   always_ff @(posedge clk) begin
      if (rst && !w_wrap) begin
         assert (r_cur <= r_nxt[WIDTH-1:0]);
      end
   end

   assign fib_out = r_cur;

endmodule : fibonacci
`default_nettype wire

// File: tb/tb_fibonacci.sv
`default_nettype none
// ============================================================================
// Module      : tb_fibonacci
// Description : Directed self-checking bench for 4- and 8-bit generators.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fibonacci;

   logic       r_clk = 1'b0;
   logic       r_rst = 1'b0;
   logic [3:0] w_fib4;
   logic [7:0] w_fib8;

   int r_tests = 0;
   int r_fails = 0;

   int c_exp4 [8]  = '{0, 1, 1, 2, 3, 5, 8, 13};
   int c_exp8 [14] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233};

   always #5 r_clk = ~r_clk;

   fibonacci #(.WIDTH(4)) u_dut4 (
      .clk     (r_clk),
      .rst     (r_rst),
      .fib_out (w_fib4)
   );

   fibonacci #(.WIDTH(8)) u_dut8 (
      .clk     (r_clk),
      .rst     (r_rst),
      .fib_out (w_fib8)
   );

   task automatic check_eq(input string tag, input int got, input int exp);
      r_tests++;
      if (got !== exp) begin
         r_fails++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge r_clk);
      #1;
   endtask

   initial begin
      bit found;

      // reset held for two edges
      r_rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         check_eq($sformatf("rst_hold4[%0d]", i), int'(w_fib4), 0);
         check_eq($sformatf("rst_hold8[%0d]", i), int'(w_fib8), 0);
      end

      // two full periods of the 4-bit sequence, including the 13 -> 0 wrap
      r_rst = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         step();
         check_eq($sformatf("period4[%0d]", i), int'(w_fib4), c_exp4[i % 8]);
      end

      // run to 8, then reset mid-sequence
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         step();
         if (w_fib4 == 4'd8) found = 1'b1;
      end
      check_eq("reach8", int'(found), 1);
      r_rst = 1'b0;
      step();
      check_eq("midrst", int'(w_fib4), 0);
      r_rst = 1'b1;
      step();
      check_eq("resume[1]", int'(w_fib4), 1);
      step();
      check_eq("resume[2]", int'(w_fib4), 1);
      step();
      check_eq("resume[3]", int'(w_fib4), 2);

      // long reset: no advance
      r_rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         check_eq($sformatf("longrst4[%0d]", i), int'(w_fib4), 0);
         check_eq($sformatf("longrst8[%0d]", i), int'(w_fib8), 0);
      end

      // 8-bit instance: 1..233 then wrap to 0, then restart at 1
      r_rst = 1'b1;
      for (int i = 1; i <= 15; i++) begin
         step();
         check_eq($sformatf("seq8[%0d]", i), int'(w_fib8), c_exp8[i % 14]);
      end

      $display("[TB] %0d tests run, %0d failed", r_tests, r_fails);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule : tb_fibonacci
`default_nettype wire
